dmem_arbiter: RTL

- Shares the single data-memory port (CACHE/RAM subsystem) between the instruction-fetch requester (I) and the load/store requester (D).
- Non-pipelined, one outstanding transaction; round-robin arbitration; fixed memory latency counted internally.
- Sits between the core's fetch/LSU stages and the data-memory block. Returns read data or a write acknowledge to the owning requester.

---
 rtl/dmem_arbiter_pkg.sv | 29 ++
 rtl/dmem_arbiter_rr_arbiter2.sv | 28 ++
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared types for the data-memory port arbiter: 32-bit bus type, FSM state,
// requester identity and the latched memory command.
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] DATA_BUS;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    // Bit position in the request/grant vectors matches the enum value.
    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

    typedef struct packed {
        DATA_BUS addr;
        DATA_BUS wdata;
        logic    we;
    } mem_cmd_t;

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   req_i        [1:0] request vector, bit 0 = fetch (I), bit 1 = load/store (D)
//   last_grant_i       requester that won the previous arbitration
//   gnt_o        [1:0] one-hot grant (all zero when nobody requests)
// -----------------------------------------------------------------------------
module rr_arbiter2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0]  req_i,
    input  requester_t  last_grant_i,
    output logic [1:0]  gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            // Contention: the side that did not win last time goes first.
            2'b11:   gnt_o = (last_grant_i == REQ_I) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one non-pipelined data-memory port between instruction fetch (I) and
// load/store (D). One transaction in flight, round-robin between requesters,
// fixed memory latency MEM_LAT counted internally.
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   i_req/i_addr               fetch request, held until i_gnt
//   i_gnt/i_rvalid/i_rdata     fetch accept, one-cycle response pulse, data
//   d_req/d_we/d_addr/d_wdata  load/store request, held until d_gnt
//   d_gnt/d_rvalid/d_rdata     load/store accept, response pulse, load data
//   m_de/m_we/m_addr/m_wdata   memory command (DE/WE/A/WD)
//   m_rdata                    memory read data (RD), valid MEM_LAT cycles
//                              after the issue cycle
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = $clog2(MEM_LAT + 1)
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        m_de,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    arb_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    requester_t       owner_q;
    requester_t       last_q;
    mem_cmd_t         cmd_q;
    logic             i_rvalid_q, d_rvalid_q;
    DATA_BUS          i_rdata_q, d_rdata_q;

    logic [1:0]       win;
    requester_t       winner;
    mem_cmd_t         issue_cmd;

    rr_arbiter2 u_rr (
        .req_i        ({d_req, i_req}),
        .last_grant_i (last_q),
        .gnt_o        (win)
    );

    assign winner    = win[1] ? REQ_D : REQ_I;
    assign issue_cmd = win[1] ? mem_cmd_t'{addr: d_addr, wdata: d_wdata, we: d_we}
                              : mem_cmd_t'{addr: i_addr, wdata: '0,      we: 1'b0};

    // Grant and memory command are combinational so the memory sees the
    // command in the issue cycle. They are forced low while reset is held so
    // a requester left asserted cannot leak a grant during reset.
    always_comb begin
        i_gnt   = 1'b0;
        d_gnt   = 1'b0;
        m_de    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (rst_n) begin
            if (state_q == IDLE) begin
                i_gnt = win[0];
                d_gnt = win[1];
                if (|win) begin
                    m_de    = 1'b1;
                    m_we    = issue_cmd.we;
                    m_addr  = issue_cmd.addr;
                    m_wdata = issue_cmd.wdata;
                end
            end else begin
                // Hold address for the read; the write already happened.
                m_de    = 1'b1;
                m_addr  = cmd_q.addr;
                m_wdata = cmd_q.wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            owner_q    <= REQ_I;
            last_q     <= REQ_I;
            cmd_q      <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            if (state_q == IDLE) begin
                if (|win) begin
                    owner_q <= winner;
                    last_q  <= winner;
                    cmd_q   <= issue_cmd;
                    cnt_q   <= CNT_W'(MEM_LAT - 1);
                    state_q <= WAIT;
                end
            end else begin
                if (cnt_q == '0) begin
                    // m_rdata is valid in this last WAIT cycle.
                    state_q <= IDLE;
                    if (owner_q == REQ_D) begin
                        d_rvalid_q <= 1'b1;
                        d_rdata_q  <= cmd_q.we ? '0 : m_rdata;
                    end else begin
                        i_rvalid_q <= 1'b1;
                        i_rdata_q  <= m_rdata;
                    end
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_gnt && d_gnt));
    a_i_rvalid_owner: assert property (@(posedge clk) disable iff (!rst_n)
        i_rvalid |-> (owner_q == REQ_I));
    a_d_rvalid_owner: assert property (@(posedge clk) disable iff (!rst_n)
        d_rvalid |-> (owner_q == REQ_D));

endmodule
